// File: rtl/shift_reg_sequencer_if.sv
// rtl/shift_reg_sequencer_if.sv - control/handshake bundle between command logic, sequencer and shift register
interface shift_reg_sequencer_if #(
  parameter int CNT_W = 7
);
  logic             start;
  logic             abort;
  logic             ser_ready;
  logic             par_load;
  logic             shift_en;
  logic             ser_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output start, abort, ser_ready,
    input  par_load, shift_en, ser_valid, busy, done, bit_cnt
  );

  modport slave (
    input  start, abort, ser_ready,
    output par_load, shift_en, ser_valid, busy, done, bit_cnt
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// rtl/shift_reg_sequencer.sv - load/shift control FSM serialising one shift-register frame LSB-first
module shift_reg_sequencer #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 7
) (
  input logic                 clk,
  input logic                 rst,
  shift_reg_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             par_load_q;
  logic             ser_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;

  // A bit leaves the register only when the consumer takes it and the frame is not being cancelled
  assign accept = (state == SHIFT) & bus.ser_ready & ~bus.abort;

  assign bus.shift_en  = accept;
  assign bus.par_load  = par_load_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bit_cnt   = cnt;

  // Next-state decode; abort overrides everything, start is only honoured from IDLE or DONE
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = LOAD;
        LOAD:    state_nxt = SHIFT;
        SHIFT:   if (bus.ser_ready && cnt == LAST_CNT) state_nxt = DONE;
        DONE:    state_nxt = bus.start ? LOAD : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, bit counter and state-decoded outputs, registered so they are glitch-free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      par_load_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      par_load_q  <= (state_nxt == LOAD);
      ser_valid_q <= (state_nxt == SHIFT);
      busy_q      <= (state_nxt == LOAD) || (state_nxt == SHIFT);
      done_q      <= (state_nxt == DONE);
      if (bus.abort) begin
        cnt <= '0;
      end else if (state_nxt == LOAD) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb/tb_shift_reg_sequencer.sv - self-checking bench for shift_reg_sequencer
module tb_shift_reg_sequencer;

  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  shift_reg_sequencer_if #(.CNT_W(7)) b24 ();
  shift_reg_sequencer_if #(.CNT_W(7)) b80 ();

  shift_reg_sequencer #(.WIDTH(24), .CNT_W(7)) dut24 (.clk(clk), .rst(rst), .bus(b24.slave));
  shift_reg_sequencer #(.WIDTH(80), .CNT_W(7)) dut80 (.clk(clk), .rst(rst), .bus(b80.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: frame-level view (in frame / load cycle / done cycle / accepted bits)
  logic m_in_frame, m_load, m_done;
  int   m_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_in_frame <= 1'b0; m_load <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
    end else if (b24.abort) begin
      m_in_frame <= 1'b0; m_load <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
    end else if (m_load) begin
      m_load <= 1'b0;
    end else if (m_in_frame) begin
      if (b24.ser_ready) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == W) begin
          m_in_frame <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end else begin
      m_done <= 1'b0;
      if (b24.start) begin
        m_in_frame <= 1'b1; m_load <= 1'b1; m_cnt <= 0;
      end
    end
  end

  // Environment: the shift register itself and the serial consumer
  logic [W-1:0] word24, sr, loaded, cap, last_cap;
  int           cap_n;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_n <= 0; cap <= '0; sr <= '0; loaded <= '0;
    end else if (b24.par_load) begin
      sr <= word24; loaded <= word24; cap <= '0; cap_n <= 0;
    end else if (b24.shift_en) begin
      if (cap_n < W) cap[cap_n] <= sr[0];
      cap_n <= cap_n + 1;
      sr <= sr >> 1;
    end
  end

  // Per-cycle comparison against the model, plus frame content check on every done pulse
  logic e_pl, e_sv, e_busy, e_done, e_se;
  always @(negedge clk) begin
    e_pl   = m_load;
    e_sv   = m_in_frame && !m_load;
    e_busy = m_in_frame;
    e_done = m_done;
    e_se   = e_sv && b24.ser_ready && !b24.abort;
    checks++;
    if (b24.par_load !== e_pl || b24.ser_valid !== e_sv || b24.busy !== e_busy ||
        b24.done !== e_done || b24.shift_en !== e_se || b24.bit_cnt !== 7'(m_cnt)) begin
      failures++;
      $display("FAIL model t=%0t: actual pl=%b sv=%b busy=%b done=%b se=%b cnt=%0d required pl=%b sv=%b busy=%b done=%b se=%b cnt=%0d",
               $time, b24.par_load, b24.ser_valid, b24.busy, b24.done, b24.shift_en, b24.bit_cnt,
               e_pl, e_sv, e_busy, e_done, e_se, m_cnt);
    end
    if (b24.done === 1'b1) begin
      check("frame_bits", 64'(cap), 64'(loaded));
      check("frame_len", 64'(cap_n), 64'(W));
      last_cap <= cap;
    end
  end

  task automatic wait_cnt(input int v);
    int n = 0;
    while (b24.bit_cnt !== 7'(v) && n < 200) begin
      tick();
      n++;
    end
    check("wait_cnt", 64'(b24.bit_cnt), 64'(v));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int seq [W] = '{0,0,0,0,1,1,1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int pl_n, pl_first, se_n, bad, done_n, done_c, cnt_at, last_acc;
    int pl_cyc [$];
    int dn_cyc [$];
    logic [W-1:0] seq_word;

    b24.start = 0; b24.abort = 0; b24.ser_ready = 1;
    b80.start = 0; b80.abort = 0; b80.ser_ready = 1;
    word24 = 24'hA5C3F0;
    seq_word = '0;
    for (int k = 0; k < W; k++) seq_word[k] = seq[k][0];

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_par_load", 64'(b24.par_load), 0);
    check("rst_shift_en", 64'(b24.shift_en), 0);
    check("rst_ser_valid", 64'(b24.ser_valid), 0);
    check("rst_busy", 64'(b24.busy), 0);
    check("rst_done", 64'(b24.done), 0);
    check("rst_bit_cnt", 64'(b24.bit_cnt), 0);
    rst = 1;
    tick();

    // basic frame, ready always 1
    b24.start = 1; tick(); b24.start = 0;
    pl_n = 0; pl_first = -1; se_n = 0; bad = 0; done_n = 0; done_c = -1; cnt_at = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (b24.par_load) begin pl_n++; if (pl_first < 0) pl_first = c; end
      if (b24.shift_en) begin se_n++; if (c < 2 || c > 25) bad++; end
      if (b24.done) begin done_n++; done_c = c; cnt_at = int'(b24.bit_cnt); end
      tick();
    end
    check("t1_par_load_cycle", 64'(pl_first), 1);
    check("t1_par_load_count", 64'(pl_n), 1);
    check("t1_shift_count", 64'(se_n), 24);
    check("t1_shift_window", 64'(bad), 0);
    check("t1_done_cycle", 64'(done_c), 26);
    check("t1_done_count", 64'(done_n), 1);
    check("t1_done_bit_cnt", 64'(cnt_at), 24);
    check("t1_bit_sequence", 64'(last_cap), 64'(seq_word));
    check("t1_word", 64'(last_cap), 64'h00A5C3F0);

    // ready pattern 1,0,0,1
    b24.start = 1; tick(); b24.start = 0;
    se_n = 0; done_n = 0; done_c = -1; last_acc = -1;
    for (int c = 1; c <= 80; c++) begin
      b24.ser_ready = pat[(c - 1) % 4];
      @(negedge clk);
      if (b24.shift_en) begin se_n++; last_acc = c; end
      if (b24.done) begin done_n++; done_c = c; end
      tick();
    end
    b24.ser_ready = 1;
    check("t2_shift_count", 64'(se_n), 24);
    check("t2_done_after_last", 64'(done_c), 64'(last_acc + 1));
    check("t2_done_count", 64'(done_n), 1);
    check("t2_word", 64'(last_cap), 64'h00A5C3F0);

    // abort at bit_cnt 10
    b24.start = 1; tick(); b24.start = 0;
    wait_cnt(10);
    b24.abort = 1;
    @(negedge clk);
    check("t3_abort_shift_en", 64'(b24.shift_en), 0);
    tick();
    b24.abort = 0;
    check("t3_abort_busy", 64'(b24.busy), 0);
    check("t3_abort_bit_cnt", 64'(b24.bit_cnt), 0);
    done_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); if (b24.done) done_n++; tick();
    end
    check("t3_no_done", 64'(done_n), 0);
    b24.start = 1; tick(); b24.start = 0;
    se_n = 0; done_n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk); if (b24.shift_en) se_n++; if (b24.done) done_n++; tick();
    end
    check("t3_refill_shifts", 64'(se_n), 24);
    check("t3_refill_done", 64'(done_n), 1);

    // start held high: back-to-back frames
    b24.start = 1; tick();
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      if (b24.par_load) pl_cyc.push_back(c);
      if (b24.done) dn_cyc.push_back(c);
      tick();
    end
    b24.start = 0;
    check("t4_par_load_count", 64'(pl_cyc.size()), 3);
    check("t4_done_count", 64'(dn_cyc.size()), 2);
    if (pl_cyc.size() == 3 && dn_cyc.size() == 2) begin
      check("t4_first_load", 64'(pl_cyc[0]), 1);
      check("t4_first_done", 64'(dn_cyc[0]), 26);
      check("t4_second_load", 64'(pl_cyc[1]), 27);
      check("t4_third_load", 64'(pl_cyc[2]), 53);
    end
    repeat (30) tick();

    // asynchronous reset mid-frame at bit_cnt 7
    b24.start = 1; tick(); b24.start = 0;
    wait_cnt(7);
    #2 rst = 0;
    #1;
    check("t5_par_load", 64'(b24.par_load), 0);
    check("t5_shift_en", 64'(b24.shift_en), 0);
    check("t5_ser_valid", 64'(b24.ser_valid), 0);
    check("t5_busy", 64'(b24.busy), 0);
    check("t5_done", 64'(b24.done), 0);
    check("t5_bit_cnt", 64'(b24.bit_cnt), 0);
    tick();
    rst = 1;
    done_n = 0; bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); if (b24.done) done_n++; if (b24.busy) bad++; tick();
    end
    check("t5_no_done", 64'(done_n), 0);
    check("t5_idle", 64'(bad), 0);
    check("t5_bit_cnt_after", 64'(b24.bit_cnt), 0);

    // 80-bit instance
    b80.start = 1; tick(); b80.start = 0;
    se_n = 0; done_n = 0; done_c = -1; cnt_at = -1;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (b80.shift_en) se_n++;
      if (b80.done) begin done_n++; done_c = c; cnt_at = int'(b80.bit_cnt); end
      tick();
    end
    check("t6_shift_count", 64'(se_n), 80);
    check("t6_done_cycle", 64'(done_c), 82);
    check("t6_done_count", 64'(done_n), 1);
    check("t6_bit_cnt", 64'(cnt_at), 80);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      word24 = W'($urandom);
      b24.ser_ready = ($urandom_range(0, 3) != 0);
      b24.start = ($urandom_range(0, 5) == 0);
      b24.abort = ($urandom_range(0, 60) == 0);
      tick();
    end
    b24.start = 0; b24.abort = 0; b24.ser_ready = 1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
